// File: rtl/sram_like_arbiter.sv
// Two-master / one-slave arbiter for the sram-like bus: DATA has fixed priority,
// an in-order owner FIFO steers each downstream response back to its issuer.
module sram_like_arbiter #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int PTR_W           = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        out_req,
  output logic        out_wr,
  output logic [1:0]  out_size,
  output logic [31:0] out_addr,
  output logic [31:0] out_wdata,
  input  logic        out_addr_ok,
  input  logic        out_data_ok,
  input  logic [31:0] out_rdata,
  output logic        resp_err
);

  typedef enum logic {OWN_INST = 1'b0, OWN_DATA = 1'b1} owner_e;

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(MAX_OUTSTANDING);

  logic                       lock_valid;
  owner_e                     lock_owner;
  owner_e                     owner;
  logic [MAX_OUTSTANDING-1:0] fifo;
  logic [PTR_W-1:0]           rd_ptr, wr_ptr;
  logic [PTR_W:0]             count;
  logic                       push, pop;
  owner_e                     head_owner;
  req_t                       inst_r, data_r, sel_r;

  always_comb begin
    owner = OWN_INST;
    if (lock_valid)    owner = lock_owner;
    else if (data_req) owner = OWN_DATA;
    else if (inst_req) owner = OWN_INST;
  end

  // Full check uses the registered count only; a same-cycle pop frees nothing.
  assign out_req = (lock_valid | inst_req | data_req) & (count != FULL_CNT);

  assign inst_r = '{wr: inst_wr, size: inst_size, addr: inst_addr, wdata: inst_wdata};
  assign data_r = '{wr: data_wr, size: data_size, addr: data_addr, wdata: data_wdata};
  assign sel_r  = (owner == OWN_DATA) ? data_r : inst_r;

  assign out_wr    = sel_r.wr;
  assign out_size  = sel_r.size;
  assign out_addr  = sel_r.addr;
  assign out_wdata = sel_r.wdata;

  assign push = out_req & out_addr_ok;
  assign pop  = out_data_ok & (count != '0);

  assign inst_addr_ok = push & (owner == OWN_INST);
  assign data_addr_ok = push & (owner == OWN_DATA);

  assign head_owner   = owner_e'(fifo[rd_ptr]);
  assign inst_data_ok = pop & (head_owner == OWN_INST);
  assign data_data_ok = pop & (head_owner == OWN_DATA);
  assign inst_rdata   = out_rdata;
  assign data_rdata   = out_rdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      lock_valid <= 1'b0;
      lock_owner <= OWN_INST;
      fifo       <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      resp_err   <= 1'b0;
    end else begin
      // Hold the granted master until the downstream handshake completes.
      if (out_req && !out_addr_ok) begin
        lock_valid <= 1'b1;
        lock_owner <= owner;
      end else if (push) begin
        lock_valid <= 1'b0;
      end

      if (push) begin
        fifo[wr_ptr] <= owner;
        wr_ptr       <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;

      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      if (out_data_ok && count == '0) resp_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed bench for sram_like_arbiter: expected response owners are queued at
// issue time and popped when the bench drives out_data_ok.
module tb_sram_like_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req, inst_wr;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr, inst_wdata;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        out_req, out_wr;
  logic [1:0]  out_size;
  logic [31:0] out_addr, out_wdata;
  logic        out_addr_ok, out_data_ok;
  logic [31:0] out_rdata;
  logic        resp_err;

  int checks = 0;
  int errors = 0;
  bit exp_q[$];   // 0 = INST, 1 = DATA

  always #5 clk = ~clk;

  sram_like_arbiter #(.MAX_OUTSTANDING(4), .PTR_W(2)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .out_req(out_req), .out_wr(out_wr), .out_size(out_size), .out_addr(out_addr),
    .out_wdata(out_wdata), .out_addr_ok(out_addr_ok), .out_data_ok(out_data_ok),
    .out_rdata(out_rdata), .resp_err(resp_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  task automatic pos();
    @(posedge clk);
    #1;
  endtask

  // Called at the negedge of a cycle in which out_data_ok is driven high.
  task automatic check_resp(input string tag, input logic [31:0] rd);
    bit o;
    if (exp_q.size() == 0) begin
      chk({tag, "_sb_underflow"}, 32'(exp_q.size()), 32'd1);
    end else begin
      o = exp_q.pop_front();
      chk({tag, "_inst_data_ok"}, 32'(inst_data_ok), 32'(!o));
      chk({tag, "_data_data_ok"}, 32'(data_data_ok), 32'(o));
      chk({tag, "_rdata"}, o ? data_rdata : inst_rdata, rd);
    end
  endtask

  task automatic drain(input string tag, input int n, input logic [31:0] base);
    for (int k = 0; k < n; k++) begin
      out_data_ok = 1'b1;
      out_rdata   = base + 32'(k);
      neg();
      check_resp(tag, base + 32'(k));
      pos();
    end
    out_data_ok = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    inst_req = 0; inst_wr = 0; inst_size = 2'd2; inst_addr = '0; inst_wdata = '0;
    data_req = 0; data_wr = 0; data_size = 2'd2; data_addr = '0; data_wdata = '0;
    out_addr_ok = 0; out_data_ok = 0; out_rdata = '0;
    pos(); pos();
    reset = 1'b0;
    neg();
    chk("rst_out_req", 32'(out_req), 32'd0);
    chk("rst_addr_ok", 32'({inst_addr_ok, data_addr_ok}), 32'd0);
    chk("rst_data_ok", 32'({inst_data_ok, data_data_ok}), 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    pos();

    // Both masters at once: DATA first, then INST.
    data_req = 1; data_addr = 32'h100; data_wr = 1; data_wdata = 32'hDEAD_BEEF;
    inst_req = 1; inst_addr = 32'hBFC0_0000; inst_wr = 0;
    out_addr_ok = 1;
    neg();
    chk("both_c0_data_addr_ok", 32'(data_addr_ok), 32'd1);
    chk("both_c0_inst_addr_ok", 32'(inst_addr_ok), 32'd0);
    chk("both_c0_out_addr", out_addr, 32'h100);
    chk("both_c0_out_wr", 32'(out_wr), 32'd1);
    chk("both_c0_out_wdata", out_wdata, 32'hDEAD_BEEF);
    exp_q.push_back(1'b1);
    pos();
    data_req = 0; data_wr = 0;
    neg();
    chk("both_c1_inst_addr_ok", 32'(inst_addr_ok), 32'd1);
    chk("both_c1_out_addr", out_addr, 32'hBFC0_0000);
    chk("both_c1_out_wr", 32'(out_wr), 32'd0);
    exp_q.push_back(1'b0);
    pos();
    inst_req = 0; out_addr_ok = 0;
    drain("both", 2, 32'hA0);

    // Lock: INST stalls three cycles while DATA arrives; INST must finish first.
    inst_req = 1; inst_addr = 32'hBFC0_0000;
    for (int c = 0; c < 3; c++) begin
      if (c == 1) begin data_req = 1; data_addr = 32'h200; end
      neg();
      chk("lock_out_addr", out_addr, 32'hBFC0_0000);
      chk("lock_addr_ok", 32'({inst_addr_ok, data_addr_ok}), 32'd0);
      pos();
    end
    out_addr_ok = 1;
    neg();
    chk("lock_c3_inst_addr_ok", 32'(inst_addr_ok), 32'd1);
    chk("lock_c3_data_addr_ok", 32'(data_addr_ok), 32'd0);
    chk("lock_c3_out_addr", out_addr, 32'hBFC0_0000);
    exp_q.push_back(1'b0);
    pos();
    inst_req = 0;
    neg();
    chk("lock_c4_data_addr_ok", 32'(data_addr_ok), 32'd1);
    chk("lock_c4_out_addr", out_addr, 32'h200);
    exp_q.push_back(1'b1);
    pos();
    data_req = 0; out_addr_ok = 0;
    drain("lock", 2, 32'hB0);

    // Fill to MAX_OUTSTANDING, fifth request stalls until a slot frees.
    out_addr_ok = 1; inst_req = 1;
    for (int c = 0; c < 4; c++) begin
      inst_addr = 32'h1000 + 32'(4 * c);
      neg();
      chk("full_fill_inst_addr_ok", 32'(inst_addr_ok), 32'd1);
      exp_q.push_back(1'b0);
      pos();
    end
    inst_req = 0; data_req = 1; data_addr = 32'h300;
    for (int c = 0; c < 2; c++) begin
      neg();
      chk("full_out_req", 32'(out_req), 32'd0);
      chk("full_data_addr_ok", 32'(data_addr_ok), 32'd0);
      pos();
    end
    out_data_ok = 1; out_rdata = 32'hC0;
    neg();
    check_resp("full_pop", 32'hC0);
    chk("full_pop_out_req", 32'(out_req), 32'd0);
    chk("full_pop_data_addr_ok", 32'(data_addr_ok), 32'd0);
    pos();
    out_data_ok = 0;
    neg();
    chk("full_after_data_addr_ok", 32'(data_addr_ok), 32'd1);
    exp_q.push_back(1'b1);
    pos();
    data_req = 0; out_addr_ok = 0;
    drain("full", 4, 32'hC1);

    // Ordering INST, DATA, INST.
    out_addr_ok = 1;
    for (int c = 0; c < 3; c++) begin
      inst_req = (c != 1); data_req = (c == 1);
      inst_addr = 32'h2000 + 32'(c); data_addr = 32'h3000 + 32'(c);
      neg();
      chk("ord_addr_ok", 32'({data_addr_ok, inst_addr_ok}), (c == 1) ? 32'd2 : 32'd1);
      exp_q.push_back(c == 1);
      pos();
    end
    inst_req = 0; data_req = 0; out_addr_ok = 0;
    for (int c = 0; c < 3; c++) begin
      out_data_ok = 1; out_rdata = 32'h11 * 32'(c + 1);
      neg();
      check_resp("ord", 32'h11 * 32'(c + 1));
      pos();
    end
    out_data_ok = 0;

    // Simultaneous push/pop at count=2 across pointer wrap.
    out_addr_ok = 1; inst_req = 1;
    for (int c = 0; c < 2; c++) begin
      neg();
      chk("pp_pre_inst_addr_ok", 32'(inst_addr_ok), 32'd1);
      exp_q.push_back(1'b0);
      pos();
    end
    for (int i = 0; i < 10; i++) begin
      inst_req = (i % 3 != 0); data_req = (i % 3 == 0);
      out_data_ok = 1; out_rdata = 32'h1000 + 32'(i);
      neg();
      check_resp("pp", 32'h1000 + 32'(i));
      chk("pp_addr_ok", 32'({data_addr_ok, inst_addr_ok}), (i % 3 == 0) ? 32'd2 : 32'd1);
      exp_q.push_back(i % 3 == 0);
      pos();
    end
    inst_req = 0; data_req = 0; out_addr_ok = 0;
    drain("pp_drain", 2, 32'hD0);
    neg();
    chk("pp_resp_err", 32'(resp_err), 32'd0);
    pos();

    // Spurious response with empty FIFO.
    out_data_ok = 1; out_rdata = 32'hEE;
    neg();
    chk("empty_data_ok", 32'({inst_data_ok, data_data_ok}), 32'd0);
    pos();
    out_data_ok = 0;
    for (int c = 0; c < 3; c++) begin
      neg();
      chk("empty_resp_err_sticky", 32'(resp_err), 32'd1);
      pos();
    end
    reset = 1;
    pos();
    reset = 0;
    neg();
    chk("rst2_resp_err", 32'(resp_err), 32'd0);
    chk("rst2_out_req", 32'(out_req), 32'd0);
    pos();
    inst_req = 1; inst_addr = 32'h4000;
    neg();
    chk("rst2_count_zero_out_req", 32'(out_req), 32'd1);
    pos();
    inst_req = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_like_arbiter.md
Name: sram_like_arbiter

Overview:
- Two-master, one-slave arbiter for the sram-like bus.
- Shares a single downstream sram-like port between the instruction-fetch requester (IF stage) and the data requester (EX issue / MEM completion).
- Tracks outstanding transactions in issue order and routes each data_ok/rdata back to the master that issued it.
- Sits between the pipeline stages and the sram-like-to-AXI bridge.

Parameters:
- MAX_OUTSTANDING, 4, depth of the in-order owner FIFO; power of two, at least 2.
- PTR_W, 2, log2(MAX_OUTSTANDING).

Ports:
- clk  input  1  clock
- reset  input  1  synchronous active-high reset
- inst_req  input  1  IF request valid; held until inst_addr_ok
- inst_wr  input  1  write flag (0 for fetch)
- inst_size  input  2  0 = byte, 1 = half, 2 = word
- inst_addr  input  32  request address
- inst_wdata  input  32  write data
- inst_addr_ok  output  1  IF request accepted this cycle
- inst_data_ok  output  1  IF response valid this cycle
- inst_rdata  output  32  IF response data
- data_req  input  1  data request valid; held until data_addr_ok
- data_wr  input  1  1 = store
- data_size  input  2  as inst_size
- data_addr  input  32  request address
- data_wdata  input  32  store data
- data_addr_ok  output  1  data request accepted this cycle
- data_data_ok  output  1  data response valid (load data or store done)
- data_rdata  output  32  data response
- out_req  output  1  downstream request
- out_wr  output  1  downstream write flag
- out_size  output  2  downstream size
- out_addr  output  32  downstream address
- out_wdata  output  32  downstream write data
- out_addr_ok  input  1  downstream accepted request
- out_data_ok  input  1  downstream response valid
- out_rdata  input  32  downstream response data
- resp_err  output  1  sticky: out_data_ok seen with no outstanding entry

Behaviour:
- Reset (synchronous, active-high): lock_valid=0, owner FIFO empty (rd_ptr=wr_ptr=0, count=0), resp_err=0. All outputs driven from this state are 0: out_req, addr_oks, data_oks.
- Owner select, combinational:
  - if lock_valid, owner=lock_owner;
  - else if data_req, owner=DATA;
  - else if inst_req, owner=INST.
  - Data has fixed priority, so MEM-side loads and stores are never starved by fetch.
- out_req = (lock_valid | inst_req | data_req) & (count != MAX_OUTSTANDING).
- out_wr, out_size, out_addr and out_wdata are muxed from the selected owner. Don't-care when out_req=0.
- Lock register:
  - Set when out_req & ~out_addr_ok: lock_valid<=1, lock_owner<=owner. Prevents switching masters mid-handshake.
  - Cleared on out_req & out_addr_ok.
  - Priority cannot pre-empt a locked request.
- Accept: inst_addr_ok = out_req & out_addr_ok & (owner==INST); data_addr_ok likewise for DATA. Zero latency, single cycle.
- FIFO push:
  - on out_req & out_addr_ok, write owner bit at wr_ptr; wr_ptr wraps modulo MAX_OUTSTANDING.
  - Full check uses the current count only. A pop in the same cycle does not free a slot for a push.
- FIFO pop and response routing:
  - on out_data_ok & count!=0: head owner bit selects inst_data_ok or data_data_ok (1 cycle, combinational); rd_ptr increments.
  - inst_rdata = data_rdata = out_rdata (passthrough); masters qualify with their data_ok.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Downstream returns data_ok no earlier than the cycle after the corresponding addr_ok, so a pop never targets the entry being pushed.
- out_data_ok with count==0: no data_ok to either master, pointers unchanged, resp_err<=1. resp_err is cleared only by reset.
- Responses are strictly in issue order; the downstream bridge guarantees ordering.
- Reset mid-operation: all outstanding tracking is discarded. Bridge and masters are reset together, so no late data_ok is delivered.
- Pipeline flush is not handled here. MEM discards cancelled responses via its own cancel logic; the arbiter still routes them to DATA.

Test Plan:
- Both masters request at once, out_addr_ok=1 constantly, data_addr=0x100, inst_addr=0xBFC00000:
  - cycle 0: data_addr_ok=1, out_addr=0x100;
  - cycle 1: inst_addr_ok=1, out_addr=0xBFC00000;
  - FIFO holds {DATA,INST}.
- inst_req alone with out_addr_ok=0 for 3 cycles, data_req rising in cycle 1:
  - out_addr stays 0xBFC00000 through the lock;
  - addr_ok in cycle 3 goes to INST;
  - DATA is granted in cycle 4.
- Issue 4 requests with no data_ok: count=4, out_req=0 and a 5th request stalls. One out_data_ok → count=3, and the stalled request is accepted the following cycle.
- Outstanding order INST,DATA,INST with out_rdata 0x11,0x22,0x33: inst_data_ok/0x11, then data_data_ok/0x22, then inst_data_ok/0x33.
- Push and pop in the same cycle at count=2: count stays 2, rd_ptr and wr_ptr both advance. Run for 10 transactions to cover pointer wrap at 3→0; all routing correct.
- out_data_ok with FIFO empty: no master data_ok, resp_err=1 and stays 1. Assert reset → resp_err=0, count=0, out_req=0.
